// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter: op encodings,
// flag bit positions and FSM state type.
package alu_share_arbiter_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FLAGS_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Any op with bit 2 set has no ALU meaning.
    function automatic logic is_illegal(input logic [2:0] op);
        return op[2];
    endfunction

    // Illegal ops are steered to a harmless add so the ALU never sees 1xx.
    function automatic logic [2:0] legal_ctrl(input logic [2:0] op);
        return op[2] ? ALU_ADD : op;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU-side bundle of the ALU sharing arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface alu_share_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*3-1:0] req_op;

    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ*N-1:0] rsp_result;
    logic [NREQ*4-1:0] rsp_flags;
    logic [NREQ-1:0]   rsp_err;

    logic [N-1:0]      alu_a;
    logic [N-1:0]      alu_b;
    logic [2:0]        alu_ctrl;
    logic [N-1:0]      alu_result;
    logic              alu_v;
    logic              alu_c;
    logic              alu_n;
    logic              alu_z;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        input  alu_result, alu_v, alu_c, alu_n, alu_z,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err,
        output alu_a, alu_b, alu_ctrl
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        output alu_result, alu_v, alu_c, alu_n, alu_z,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err,
        input  alu_a, alu_b, alu_ctrl
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on contention the
// pointer decides, and every accepted grant hands priority to the other side.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o     = 2'b00;
        gnt_idx_o = 1'b0;
        if (req_i == 2'b11) begin
            gnt_idx_o = ptr_q;
            gnt_o     = ptr_q ? 2'b10 : 2'b01;
        end else if (req_i[1]) begin
            gnt_idx_o = 1'b1;
            gnt_o     = 2'b10;
        end else if (req_i[0]) begin
            gnt_idx_o = 1'b0;
            gnt_o     = 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = ~gnt_idx_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters: round-robin
// grant, registered operands, one EXEC cycle, per-requester response buffer.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   gnt;
    logic              gnt_idx;
    logic              load;
    logic              capture;

    logic [N-1:0]      sel_a, sel_b;
    logic [2:0]        sel_op;
    logic [N-1:0]      alu_a_q, alu_a_d;
    logic [N-1:0]      alu_b_q, alu_b_d;
    logic [2:0]        alu_ctrl_q, alu_ctrl_d;
    logic              err_q, err_d;
    logic              idx_q, idx_d;
    logic [FLAGS_W-1:0] alu_flags;

    logic [NREQ-1:0]   rsp_valid_q;
    logic [NREQ-1:0]   rsp_err_q;

    // A full response buffer blocks its owner until the buffer is consumed.
    assign elig    = bus.req_valid & ~rsp_valid_q;
    assign arb_req = (state_q == IDLE) ? elig : '0;

    rr_arb2 u_rr_arb2 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (arb_req),
        .adv_i     (load),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|gnt) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        load          = 1'b0;
        capture       = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = gnt;
                load          = |gnt;
            end
            EXEC:    capture = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        sel_a  = bus.req_a[N-1:0];
        sel_b  = bus.req_b[N-1:0];
        sel_op = bus.req_op[2:0];
        if (gnt_idx) begin
            sel_a  = bus.req_a[2*N-1:N];
            sel_b  = bus.req_b[2*N-1:N];
            sel_op = bus.req_op[5:3];
        end
    end

    // Operand registers hold between grants to keep the ALU inputs quiet.
    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        err_d      = err_q;
        idx_d      = idx_q;
        if (load) begin
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            alu_ctrl_d = legal_ctrl(sel_op);
            err_d      = is_illegal(sel_op);
            idx_d      = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= ALU_ADD;
            err_q      <= 1'b0;
            idx_q      <= 1'b0;
        end else begin
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_N] = bus.alu_n;
        alu_flags[FLAG_Z] = bus.alu_z;
        alu_flags[FLAG_C] = bus.alu_c;
        alu_flags[FLAG_V] = bus.alu_v;
    end

    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_ctrl = alu_ctrl_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        logic               cap;
        logic               valid_d, err_buf_d;
        logic [N-1:0]       result_q, result_d;
        logic [FLAGS_W-1:0] flags_q, flags_d;

        assign cap = capture && (idx_q == 1'(i));

        // Capture and consume never coincide: a full buffer cannot be granted.
        always_comb begin
            valid_d   = rsp_valid_q[i];
            err_buf_d = rsp_err_q[i];
            result_d  = result_q;
            flags_d   = flags_q;
            if (cap) begin
                valid_d   = 1'b1;
                err_buf_d = err_q;
                result_d  = err_q ? '0 : bus.alu_result;
                flags_d   = err_q ? '0 : alu_flags;
            end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
                valid_d   = 1'b0;
                err_buf_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rsp_valid_q[i] <= 1'b0;
                rsp_err_q[i]   <= 1'b0;
                result_q       <= '0;
                flags_q        <= '0;
            end else begin
                rsp_valid_q[i] <= valid_d;
                rsp_err_q[i]   <= err_buf_d;
                result_q       <= result_d;
                flags_q        <= flags_d;
            end
        end

        assign bus.rsp_result[i*N +: N]         = result_q;
        assign bus.rsp_flags[i*FLAGS_W +: FLAGS_W] = flags_q;
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the
// ALU-side signals; vectors carry hand-computed result/flag expectations.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int N = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.N(N), .NREQ(2)) bus ();

    alu_share_arbiter #(.N(N), .NREQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU: C is carry-out of a + ~b + 1 for sub (no-borrow).
    logic [32:0] m_sum;
    logic [31:0] m_res;
    logic        m_c, m_v;
    always_comb begin
        m_sum = '0;
        m_res = '0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (bus.alu_ctrl)
            ALU_ADD: begin
                m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (bus.alu_a[31] == bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
            end
            ALU_SUB: begin
                m_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (bus.alu_a[31] != bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
            end
            ALU_AND: m_res = bus.alu_a & bus.alu_b;
            ALU_OR:  m_res = bus.alu_a | bus.alu_b;
            default: m_res = '0;
        endcase
    end
    assign bus.alu_result = m_res;
    assign bus.alu_n      = m_res[31];
    assign bus.alu_z      = (m_res == 32'd0);
    assign bus.alu_c      = m_c;
    assign bus.alu_v      = m_v;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         rq;
        logic [2:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic drive_req(input int rq, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        bus.req_a[rq*N +: N]  = a;
        bus.req_b[rq*N +: N]  = b;
        bus.req_op[rq*3 +: 3] = op;
        bus.req_valid[rq]     = 1'b1;
    endtask

    task automatic wait_ready(input int rq, input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.req_ready[rq]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk(name, 64'(got), 64'd1);
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        @(negedge clk);
        drive_req(v.rq, v.op, v.a, v.b);
        #1;
        wait_ready(v.rq, $sformatf("v%0d_ready", k));
        chk($sformatf("v%0d_ready_onehot", k), 64'(bus.req_ready), 64'd1 << v.rq);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk($sformatf("v%0d_valid_early", k), 64'(bus.rsp_valid[v.rq]), 64'd0);
        chk($sformatf("v%0d_alu_a", k), 64'(bus.alu_a), 64'(v.a));
        chk($sformatf("v%0d_alu_ctrl", k), 64'(bus.alu_ctrl), v.op[2] ? 64'd0 : 64'(v.op));
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_rsp_valid", k), 64'(bus.rsp_valid), 64'd1 << v.rq);
        chk($sformatf("v%0d_result", k), 64'(bus.rsp_result[v.rq*N +: N]), 64'(v.res));
        chk($sformatf("v%0d_flags", k), 64'(bus.rsp_flags[v.rq*4 +: 4]), 64'(v.flg));
        chk($sformatf("v%0d_err", k), 64'(bus.rsp_err[v.rq]), 64'(v.err));
        bus.rsp_ready[v.rq] = 1'b1;
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_consumed", k), 64'(bus.rsp_valid[v.rq]), 64'd0);
        chk($sformatf("v%0d_err_clr", k), 64'(bus.rsp_err[v.rq]), 64'd0);
        bus.rsp_ready = '0;
    endtask

    int   gidx[$];
    int   gcyc[$];
    int   g0, g1;
    bit   stable, seen;
    logic [31:0] hold_res;

    initial begin
        vecs[0] = '{0, ALU_ADD, 32'd7,          32'd5,          32'd12,         4'b0000, 1'b0};
        vecs[1] = '{1, ALU_SUB, 32'd5,          32'd7,          32'hFFFF_FFFE,  4'b1000, 1'b0};
        vecs[2] = '{0, ALU_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b0011, 1'b0};
        vecs[3] = '{1, ALU_SUB, 32'd3,          32'd3,          32'd0,          4'b0110, 1'b0};
        vecs[4] = '{0, ALU_AND, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'd0,          4'b0100, 1'b0};
        vecs[5] = '{1, ALU_OR,  32'h8000_0000,  32'd1,          32'h8000_0001,  4'b1000, 1'b0};
        vecs[6] = '{1, ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0110, 1'b0};
        vecs[7] = '{0, ALU_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1001, 1'b0};
        vecs[8] = '{0, 3'b110,  32'd5,          32'd5,          32'd0,          4'b0000, 1'b1};
        vecs[9] = '{1, 3'b111,  32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0000, 1'b1};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
        chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
        chk("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            run_vec(k);
        end

        // Both requesters streaming with responses drained every cycle
        @(negedge clk);
        bus.rsp_ready = 2'b11;
        drive_req(0, ALU_ADD, 32'd1, 32'd1);
        drive_req(1, ALU_ADD, 32'd2, 32'd2);
        for (int c = 0; c < 16; c++) begin
            #1;
            if (|(bus.req_valid & bus.req_ready)) begin
                gidx.push_back(bus.req_ready[1] ? 1 : 0);
                gcyc.push_back(c);
            end
            @(negedge clk);
        end
        chk("alt_count", 64'(gidx.size()), 64'd8);
        for (int j = 1; j < gidx.size(); j++) begin
            chk($sformatf("alt_swap%0d", j), 64'(gidx[j] != gidx[j-1]), 64'd1);
            chk($sformatf("alt_gap%0d", j), 64'(gcyc[j] - gcyc[j-1]), 64'd2);
        end

        // Requester 0 stops consuming: it must never be granted again
        bus.rsp_ready[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.rsp_valid[0]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("hold_rsp0_full", 64'(seen), 64'd1);
        hold_res = bus.rsp_result[31:0];
        chk("hold_rsp0_result", 64'(hold_res), 64'd2);
        g0 = 0;
        g1 = 0;
        stable = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            bus.req_a[31:0] = 32'(c + 100);
            #1;
            if (bus.req_valid[0] && bus.req_ready[0]) g0++;
            if (bus.req_valid[1] && bus.req_ready[1]) g1++;
            if (bus.rsp_result[31:0] !== hold_res || bus.rsp_valid[0] !== 1'b1) stable = 1'b0;
        end
        chk("hold_req0_grants", 64'(g0), 64'd0);
        chk("hold_req1_served", 64'(g1 >= 5), 64'd1);
        chk("hold_rsp0_stable", 64'(stable), 64'd1);

        @(negedge clk);
        bus.req_valid = '0;
        bus.rsp_ready = 2'b11;
        repeat (4) @(negedge clk);
        bus.rsp_ready = '0;
        #1;
        chk("drain_empty", 64'(bus.rsp_valid), 64'd0);

        // Reset during EXEC discards the in-flight operation
        @(negedge clk);
        drive_req(0, ALU_ADD, 32'd7, 32'd5);
        #1;
        wait_ready(0, "rexec_ready");
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rexec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rexec_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("rexec_rsp_flags", 64'(bus.rsp_flags), 64'd0);
        chk("rexec_alu_a", 64'(bus.alu_a), 64'd0);
        chk("rexec_alu_b", 64'(bus.alu_b), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rexec_quiet%0d", c), 64'(bus.rsp_valid), 64'd0);
        end
        @(negedge clk);
        drive_req(0, ALU_ADD, 32'd1, 32'd1);
        drive_req(1, ALU_ADD, 32'd2, 32'd2);
        #1;
        chk("rexec_first_grant", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
